// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: FSM state encoding, end-of-run
// status codes and a small sizing helper.
package cpu_run_pkg;

  localparam int unsigned STATUS_W = 2;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } run_state_e;

  typedef enum logic [STATUS_W-1:0] {
    ST_NONE    = 2'd0,
    ST_HALT    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_HANG    = 2'd3
  } run_status_e;

  // Largest of three values; sizes the shared HOLD/RUN/DRAIN phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    return (((a > b) ? a : b) > c) ? ((a > b) ? a : b) : c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Ports: clk, clr (sync clear), en (count enable), count (registered value).
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run-control harness for the CPU bench: stretches the system reset into a
// CPU reset pulse, counts run cycles and retired instructions, and ends the
// run on halt request (after a drain window), cycle-budget timeout or a
// stuck-PC hang.
// Ports: clk, reset (sync, active high), pc/pc_valid (fetch PC and update
// strobe), retire, halt_req -> cpu_reset, running, done, status (end cause),
// cycle_count, instr_count. All outputs are registered.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 187,
  parameter int unsigned HANG_LIMIT   = 8,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 pc_valid,
  input  logic                 retire,
  input  logic                 halt_req,
  output logic                 cpu_reset,
  output logic                 running,
  output logic                 done,
  output logic [STATUS_W-1:0]  status,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  // One phase counter serves HOLD, RUN (budget) and DRAIN, so the timeout
  // still fires when the visible cycle counter is narrow and saturated.
  localparam int unsigned PH_W   = $clog2(max3(RESET_CYCLES, DRAIN_CYCLES, MAX_CYCLES) + 1);
  localparam int unsigned HANG_W = $clog2(HANG_LIMIT + 1);

  run_state_e          state_q, state_nxt;
  run_status_e         status_q, status_nxt;
  logic [PH_W-1:0]     phase_cnt;
  logic [HANG_W-1:0]   hang_cnt;
  logic [PC_WIDTH-1:0] last_pc;
  logic                pc_seen;
  logic                phase_clr, phase_en;
  logic                cnt_en, track, pc_same;

  // Next-state and end-cause decode.
  always_comb begin
    state_nxt  = state_q;
    status_nxt = status_q;
    phase_clr  = 1'b0;
    phase_en   = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        phase_en = 1'b1;
        if (phase_cnt == PH_W'(RESET_CYCLES - 1)) begin
          state_nxt = S_RUN;
          phase_clr = 1'b1;
        end
      end
      S_RUN: begin
        phase_en = 1'b1;
        if (halt_req) begin
          state_nxt  = S_DRAIN;
          status_nxt = ST_HALT;
          phase_clr  = 1'b1;
        end else if (phase_cnt == PH_W'(MAX_CYCLES - 1)) begin
          state_nxt  = S_DONE;
          status_nxt = ST_TIMEOUT;
        end else if (hang_cnt == HANG_W'(HANG_LIMIT - 1)) begin
          state_nxt  = S_DONE;
          status_nxt = ST_HANG;
        end
      end
      S_DRAIN: begin
        phase_en = 1'b1;
        if (phase_cnt == PH_W'(DRAIN_CYCLES - 1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: ;
      default: ;
    endcase
  end

  // State register and registered outputs; reset aborts from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HOLD;
      status_q  <= ST_NONE;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      status_q  <= status_nxt;
      cpu_reset <= (state_nxt == S_HOLD);
      running   <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done      <= (state_nxt == S_DONE);
    end
  end

  assign status = status_q;

  assign cnt_en  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign track   = (state_q == S_RUN) && pc_valid;
  assign pc_same = pc_seen && (pc == last_pc);

  // Last valid PC; the first valid sample of a run only loads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc <= '0;
      pc_seen <= 1'b0;
    end else if (track) begin
      last_pc <= pc;
      pc_seen <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(PH_W)) u_phase (
    .clk   (clk),
    .clr   (reset || phase_clr),
    .en    (phase_en),
    .count (phase_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
    .clk   (clk),
    .clr   (reset),
    .en    (cnt_en),
    .count (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instrs (
    .clk   (clk),
    .clr   (reset),
    .en    (cnt_en && retire),
    .count (instr_count)
  );

  // Consecutive repeats of the same valid PC; stalls (pc_valid low) hold it.
  sat_counter #(.WIDTH(HANG_W)) u_hang (
    .clk   (clk),
    .clr   (reset || (track && !pc_same)),
    .en    (track && pc_same),
    .count (hang_cnt)
  );

endmodule
